traffic_phase_ctrl: RTL

Timed phase sequencer for the four-approach intersection in normal operation. It produces the 2-bit `traffic_light` code that the downstream normal-operation decoder turns into one-hot `allow_*_norm` grants. For each approach it holds a green interval, then a yellow interval, then advances to the next approach. An optional demand-skip feature uses per-approach car sensors to bypass idle approaches.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/next_lane_sel.sv | 28 ++
 rtl/traffic_phase_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the normal-operation traffic phase sequencer and its downstream decoder.
package traffic_pkg;

  localparam int unsigned NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  typedef enum logic {
    GREEN  = 1'b0,
    YELLOW = 1'b1
  } phase_state_t;

endpackage : traffic_pkg

// File: rtl/next_lane_sel.sv
// Rotating priority select: first approach after cur_lane with a waiting vehicle,
// or cur_lane itself when no other approach has demand.
module next_lane_sel
  import traffic_pkg::*;
(
  input  lane_t                cur_lane,
  input  logic [NUM_LANES-1:0] car_present,
  output lane_t                next_lane
);

  lane_t cand;
  logic  found;

  always_comb begin
    next_lane = cur_lane;
    cand      = cur_lane;
    found     = 1'b0;
    // Search L+1, L+2, L+3 in order; 2-bit wrap gives the modulo-4 rotation.
    for (int k = 1; k < NUM_LANES; k++) begin
      cand = cur_lane + lane_t'(k);
      if (!found && car_present[cand]) begin
        next_lane = cand;
        found     = 1'b1;
      end
    end
  end

endmodule : next_lane_sel

// File: rtl/traffic_phase_ctrl.sv
// Timed green/yellow phase sequencer for a four-approach intersection.
// Optional demand-based skipping of idle approaches under TRAFFIC_SKIP_EMPTY_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] car_present,
  output lane_t                traffic_light,
  output logic                 yellow,
  output logic                 phase_start
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  phase_state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  lane_t            light_d;
  logic             yellow_d;
  logic             phase_start_d;
  lane_t            next_lane;

`ifdef TRAFFIC_SKIP_EMPTY_EN
  next_lane_sel u_next_lane_sel (
    .cur_lane    (traffic_light),
    .car_present (car_present),
    .next_lane   (next_lane)
  );
`else
  logic unused_car_present;

  assign unused_car_present = ^car_present;
  assign next_lane          = traffic_light + lane_t'(1);
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= GREEN;
      cnt           <= '0;
      traffic_light <= '0;
      yellow        <= 1'b0;
      phase_start   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      traffic_light <= light_d;
      yellow        <= yellow_d;
      phase_start   <= phase_start_d;
    end
  end

  // Interval counting and phase transitions; everything holds while en is low,
  // except phase_start which always self-clears.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    light_d       = traffic_light;
    yellow_d      = yellow;
    phase_start_d = 1'b0;
    if (en) begin
      unique case (state)
        GREEN: begin
          if (cnt == GREEN_LAST) begin
            cnt_d    = '0;
            state_d  = YELLOW;
            yellow_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        YELLOW: begin
          if (cnt == YELLOW_LAST) begin
            cnt_d         = '0;
            state_d       = GREEN;
            yellow_d      = 1'b0;
            light_d       = next_lane;
            phase_start_d = 1'b1;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule : traffic_phase_ctrl
